// File: rtl/mem_stage_wb.sv
// MEM pipeline stage and MEM/WB register for the 5-stage MIPS-Lite CPU.
// Word-addressed data memory with combinational read and synchronous store.
// The MEM/WB register has a synchronous active-high reset and a hold (stall) input.
// The writeback mux is combinational on the registered values.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, the stage
// suppresses misaligned stores, kills register writes on misaligned loads and
// reports the condition on out_misalign.
module mem_stage_wb #(
    parameter int DMEM_DEPTH = 32,
    parameter int DMEM_AW    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [31:0] ALU_out,
    input  logic [31:0] rd2,
    input  logic [4:0]  wn,
    output logic        out_MemtoReg,
    output logic        out_RegWrite,
    output logic [31:0] out_rd,
    output logic [31:0] out_ALU_out,
    output logic [4:0]  out_wn,
    output logic [31:0] wb_data,
    output logic        out_misalign
);

    logic [31:0]        mem [DMEM_DEPTH];
    logic [DMEM_AW-1:0] idx;
    logic [31:0]        rd_word;
    logic               misalign;
    logic               store_en;
    logic               reg_write_d;
    logic               misalign_q;

    // Byte address to word index. Address bits above the index wrap modulo the memory size.
    assign idx     = ALU_out[DMEM_AW+1:2];
    assign rd_word = mem[idx];

    // Alignment qualification of the store enable and of the register write.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        misalign    = 1'b0;
        store_en    = MemWrite;
        reg_write_d = RegWrite;
`ifdef DMEM_ALIGN_CHECK_EN
        misalign    = (MemRead | MemWrite) && (ALU_out[1:0] != 2'b00);
        store_en    = MemWrite && !misalign;
        reg_write_d = RegWrite && !(MemRead && misalign);
`endif
    end

    // Data memory store. It is blocked during reset and during a stall.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; its contents survive rst so it can map to RAM.
        if (!rst && !hold && store_en) begin
            mem[idx] <= rd2;
        end
    end

    // MEM/WB pipeline register. Reset takes priority over hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_MemtoReg <= 1'b0;
            out_RegWrite <= 1'b0;
            out_rd       <= '0;
            out_ALU_out  <= '0;
            out_wn       <= '0;
            misalign_q   <= 1'b0;
        end else if (!hold) begin
            out_MemtoReg <= MemtoReg;
            out_RegWrite <= reg_write_d;
            out_rd       <= rd_word;
            out_ALU_out  <= ALU_out;
            out_wn       <= wn;
            misalign_q   <= misalign;
        end
    end

    // Without the alignment check, misalign is constant 0, so this register stays 0 after reset.
    assign out_misalign = misalign_q;

    // Writeback mux that drives the register file write data.
    assign wb_data = out_MemtoReg ? out_rd : out_ALU_out;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Self-checking bench for mem_stage_wb.
// A behavioural model (a word array plus the expected MEM/WB register contents)
// is advanced once per clock. It is compared with the DUT 1 ns after each rising edge.
// The alignment scenarios are built only when DMEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage_wb;

    logic        clk = 1'b0;
    logic        rst, hold, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [31:0] ALU_out, rd2;
    logic [4:0]  wn;
    logic        out_MemtoReg, out_RegWrite, out_misalign;
    logic [31:0] out_rd, out_ALU_out, wb_data;
    logic [4:0]  out_wn;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] mem_m [32];
    bit          mem_v [32];
    logic        e_mtr, e_rw, e_mis;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wn;
    bit          e_rd_v;

    mem_stage_wb #(.DMEM_DEPTH(32), .DMEM_AW(5)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALU_out(ALU_out), .rd2(rd2), .wn(wn),
        .out_MemtoReg(out_MemtoReg), .out_RegWrite(out_RegWrite), .out_rd(out_rd),
        .out_ALU_out(out_ALU_out), .out_wn(out_wn), .wb_data(wb_data),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model and checks every output after the edge.
    task automatic cycle(input bit r, input bit h, input bit mr, input bit mw, input bit mtr,
                         input bit rw, input logic [31:0] alu, input logic [31:0] d,
                         input logic [4:0] w);
        int  i;
        bit  mis;
        @(negedge clk);
        rst = r; hold = h; MemRead = mr; MemWrite = mw; MemtoReg = mtr; RegWrite = rw;
        ALU_out = alu; rd2 = d; wn = w;
        i = int'((alu / 32'd4) % 32'd32);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (mr || mw) && (alu % 32'd4 != 32'd0);
`else
        mis = 1'b0;
`endif
        if (r) begin
            e_mtr = 0; e_rw = 0; e_rd = 0; e_rd_v = 1; e_alu = 0; e_wn = 0; e_mis = 0;
        end else if (!h) begin
            e_mtr  = mtr;
            e_rw   = rw && !(mr && mis);
            e_rd   = mem_m[i];
            e_rd_v = mem_v[i];
            e_alu  = alu;
            e_wn   = w;
            e_mis  = mis;
            if (mw && !mis) begin
                mem_m[i] = d;
                mem_v[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("out_MemtoReg", 32'(out_MemtoReg), 32'(e_mtr));
        check("out_RegWrite", 32'(out_RegWrite), 32'(e_rw));
        check("out_ALU_out", out_ALU_out, e_alu);
        check("out_wn", 32'(out_wn), 32'(e_wn));
        check("out_misalign", 32'(out_misalign), 32'(e_mis));
        if (e_rd_v) check("out_rd", out_rd, e_rd);
        if (e_rd_v || !e_mtr) check("wb_data", wb_data, e_mtr ? e_rd : e_alu);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_m[i] = '0;
            mem_v[i] = 1'b0;
        end
        e_mtr = 0; e_rw = 0; e_rd = 0; e_rd_v = 1; e_alu = 0; e_wn = 0; e_mis = 0;
        rst = 1; hold = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        ALU_out = 0; rd2 = 0; wn = 0;

        // Power-up reset, then fill every memory word so later loads have known data.
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 32; i++)
            cycle(0, 0, 0, 1, 0, 0, 32'(i * 4), $urandom, 5'd0);

        // Reset with random inputs: outputs clear, stores are blocked and mem[3] survives.
        cycle(0, 0, 0, 1, 0, 0, 32'h0C, 32'h3333_0003, 5'd0);
        for (int k = 0; k < 2; k++)
            cycle(1, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom),
                  32'h0C, $urandom, 5'($urandom));
        cycle(0, 0, 1, 0, 1, 1, 32'h0C, 32'h0, 5'd1);

        // Store followed by a load of the same word returns the new data.
        cycle(0, 0, 0, 1, 0, 0, 32'h0C, 32'hDEAD_BEEF, 5'd0);
        cycle(0, 0, 1, 0, 1, 1, 32'h0C, 32'h0, 5'd8);

        // R-type result passes through to writeback.
        cycle(0, 0, 0, 0, 0, 1, 32'h1234, 32'h0, 5'd5);

        // A stall freezes the register and blocks the store; the store completes after the stall.
        cycle(0, 1, 0, 1, 0, 0, 32'h10, 32'h55, 5'd2);
        cycle(0, 0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd3);
        cycle(0, 0, 0, 1, 0, 0, 32'h10, 32'h55, 5'd2);
        cycle(0, 0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd3);

        // Addresses wrap modulo the memory size; a same-cycle read and write returns the old value.
        cycle(0, 0, 0, 1, 0, 0, 32'h84, 32'hA5, 5'd0);
        cycle(0, 0, 1, 1, 1, 1, 32'h04, 32'h77, 5'd9);
        cycle(0, 0, 1, 0, 1, 1, 32'h04, 32'h0, 5'd9);

`ifdef DMEM_ALIGN_CHECK_EN
        // A misaligned store is dropped and flagged; a misaligned load loses its register write.
        cycle(0, 0, 0, 1, 0, 0, 32'h0D, 32'hBAD0_BAD0, 5'd0);
        cycle(0, 0, 1, 0, 1, 1, 32'h0C, 32'h0, 5'd4);
        cycle(0, 0, 1, 0, 1, 1, 32'h0E, 32'h0, 5'd4);
`endif

        // Random traffic with occasional stalls and resets.
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
